and4_sweep_ctrl: RTL and testbench

//   Self-checking sequencer for the 4-input AND gate datapath (AND_4Input).
//   - On a start pulse, drives every input vector 0 .. 2^WIDTH-1 onto the gate, in order.
//   - Samples the gate output Y after a settle delay and compares it with the expected reduction-AND.
//   - Reports the error count, the first failing vector and an overall pass flag.
//   - Sits beside the gate in the bring-up harness, replacing the hand-written vector list.

---
 rtl/and4_sweep_ctrl.sv | 135 +++++++++++++
 tb/tb_and4_sweep_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/and4_sweep_ctrl.sv
// Exhaustive sweep sequencer for the AND-gate bring-up harness: drives every input
// vector, checks Y against the reduction-AND and reports error count and first failure.
module and4_sweep_ctrl #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] a_out,
    input  logic             y_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             done_seen,
    output logic [WIDTH:0]   err_count,
    output logic [WIDTH-1:0] first_fail,
    output logic             fail_valid
);

    localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [WIDTH:0] ERR_MAX = {1'b1, {WIDTH{1'b0}}};

    typedef enum logic [1:0] {StIdle, StDrive, StCheck, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] vec_q, vec_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [WIDTH:0]   err_count_q, err_count_d;
    logic [WIDTH-1:0] first_fail_q, first_fail_d;
    logic             fail_valid_q, fail_valid_d;
    logic             pass_q, pass_d;
    logic             done_seen_q, done_seen_d;
    logic             mismatch;

    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        settle_d     = settle_q;
        err_count_d  = err_count_q;
        first_fail_d = first_fail_q;
        fail_valid_d = fail_valid_q;
        pass_d       = pass_q;
        done_seen_d  = done_seen_q;
        a_out        = '0;
        busy         = 1'b0;
        done         = 1'b0;
        mismatch     = (y_in != (&vec_q));

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d      = StDrive;
                    vec_d        = '0;
                    settle_d     = '0;
                    err_count_d  = '0;
                    first_fail_d = '0;
                    fail_valid_d = 1'b0;
                    done_seen_d  = 1'b0;
                    pass_d       = 1'b0;
                end
            end
            StDrive: begin
                a_out = vec_q;
                busy  = 1'b1;
                if (settle_q == SETTLE_LAST) begin
                    state_d = StCheck;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            StCheck: begin
                a_out = vec_q;
                busy  = 1'b1;
                if (mismatch) begin
                    // Saturate defensively; a single sweep can reach ERR_MAX but never exceed it
                    if (err_count_q != ERR_MAX) begin
                        err_count_d = err_count_q + (WIDTH+1)'(1);
                    end
                    if (!fail_valid_q) begin
                        first_fail_d = vec_q;
                        fail_valid_d = 1'b1;
                    end
                end
                // Terminal compare precedes the increment so vec never wraps
                if (vec_q == '1) begin
                    state_d = StDone;
                end else begin
                    vec_d    = vec_q + WIDTH'(1);
                    settle_d = '0;
                    state_d  = StDrive;
                end
            end
            StDone: begin
                done        = 1'b1;
                done_seen_d = 1'b1;
                pass_d      = (err_count_q == '0);
                state_d     = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            vec_q        <= '0;
            settle_q     <= '0;
            err_count_q  <= '0;
            first_fail_q <= '0;
            fail_valid_q <= 1'b0;
            pass_q       <= 1'b0;
            done_seen_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            settle_q     <= settle_d;
            err_count_q  <= err_count_d;
            first_fail_q <= first_fail_d;
            fail_valid_q <= fail_valid_d;
            pass_q       <= pass_d;
            done_seen_q  <= done_seen_d;
        end
    end

    assign err_count  = err_count_q;
    assign first_fail = first_fail_q;
    assign fail_valid = fail_valid_q;
    assign pass       = pass_q;
    assign done_seen  = done_seen_q;

endmodule

// File: tb/tb_and4_sweep_ctrl.sv
// Scoreboard bench for and4_sweep_ctrl: one instance at SETTLE=2 with a selectable gate
// model, one at SETTLE=1 wired to an inverted gate.
module tb_and4_sweep_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start_a, start_b, y_a, y_b;
    logic [3:0] a_a, a_b, ff_a, ff_b;
    logic [4:0] ec_a, ec_b;
    logic       busy_a, done_a, pass_a, ds_a, fv_a;
    logic       busy_b, done_b, pass_b, ds_b, fv_b;
    int         mode;

    and4_sweep_ctrl #(.WIDTH(4), .SETTLE(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .a_out(a_a), .y_in(y_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .done_seen(ds_a),
        .err_count(ec_a), .first_fail(ff_a), .fail_valid(fv_a)
    );

    and4_sweep_ctrl #(.WIDTH(4), .SETTLE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .a_out(a_b), .y_in(y_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .done_seen(ds_b),
        .err_count(ec_b), .first_fail(ff_b), .fail_valid(fv_b)
    );

    // Gate models: 0 = AND, 1 = Y stuck at 0, 2 = OR, other = NAND
    always_comb begin
        case (mode)
            0:       y_a = &a_a;
            1:       y_a = 1'b0;
            2:       y_a = |a_a;
            default: y_a = ~&a_a;
        endcase
    end
    assign y_b = ~&a_b;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int start_cyc;
        int lat;
        int errs;
        int ff;
        int fv;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    task automatic push(input int id, input int c, input int lat, input int errs,
                        input int ff, input int fv);
        exp_t e;
        e.start_cyc = c;
        e.lat       = lat;
        e.errs      = errs;
        e.ff        = ff;
        e.fv        = fv;
        if (id == 0) q_a.push_back(e);
        else         q_b.push_back(e);
    endtask

    // Monitor state per instance
    int bcnt[2];
    bit pend[2];
    bit pend_pass[2];

    task automatic mon_step(input int id, input int settle, input logic busy, input logic done,
                            input logic ds, input logic ps, input logic fv,
                            input logic [3:0] a, input logic [3:0] ff, input logic [4:0] ec);
        exp_t e;
        int   qs;
        if (pend[id]) begin
            check($sformatf("pass[%0d]", id), ps, pend_pass[id]);
            check($sformatf("done_seen[%0d]", id), ds, 1);
            pend[id] = 1'b0;
        end
        if (busy) begin
            if (bcnt[id] == 0) begin
                check($sformatf("err_count cleared[%0d]", id), ec, 0);
                check($sformatf("fail_valid cleared[%0d]", id), fv, 0);
                check($sformatf("done_seen cleared[%0d]", id), ds, 0);
            end
            check($sformatf("a_out step[%0d]", id), a, bcnt[id] / (settle + 1));
            bcnt[id]++;
        end else begin
            bcnt[id] = 0;
        end
        if (done) begin
            qs = (id == 0) ? q_a.size() : q_b.size();
            check($sformatf("done expected[%0d]", id), qs > 0, 1);
            if (qs > 0) begin
                e = (id == 0) ? q_a.pop_front() : q_b.pop_front();
                check($sformatf("done latency[%0d]", id), cyc - e.start_cyc, e.lat);
                check($sformatf("a_out in done[%0d]", id), a, 0);
                check($sformatf("err_count[%0d]", id), ec, e.errs);
                check($sformatf("first_fail[%0d]", id), ff, e.ff);
                check($sformatf("fail_valid[%0d]", id), fv, e.fv);
                pend[id]      = 1'b1;
                pend_pass[id] = (e.errs == 0);
            end
        end
    endtask

    always @(negedge clk) begin
        mon_step(0, 2, busy_a, done_a, ds_a, pass_a, fv_a, a_a, ff_a, ec_a);
        mon_step(1, 1, busy_b, done_b, ds_b, pass_b, fv_b, a_b, ff_b, ec_b);
    end

    task automatic pulse(input int id, output int c);
        @(negedge clk);
        if (id == 0) start_a = 1'b1;
        else         start_b = 1'b1;
        c = cyc;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input int id, input int limit);
        int n = 0;
        while (((id == 0) ? done_a : done_b) !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("done within bound[%0d]", id), (id == 0) ? done_a : done_b, 1);
        @(negedge clk);
    endtask

    task automatic check_zero_a(input string tag);
        check({tag, " a_out"}, a_a, 0);
        check({tag, " busy"}, busy_a, 0);
        check({tag, " done"}, done_a, 0);
        check({tag, " pass"}, pass_a, 0);
        check({tag, " done_seen"}, ds_a, 0);
        check({tag, " err_count"}, ec_a, 0);
        check({tag, " first_fail"}, ff_a, 0);
        check({tag, " fail_valid"}, fv_a, 0);
    endtask

    initial begin
        int c;
        int d;
        int n;
        rst_n   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        mode    = 0;
        #12;
        check_zero_a("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Correct AND gate
        mode = 0;
        pulse(0, c);
        push(0, c, 49, 0, 0, 0);
        wait_done(0, 60);

        // Y stuck at 0
        mode = 1;
        pulse(0, c);
        push(0, c, 49, 1, 15, 1);
        wait_done(0, 60);

        // OR gate substituted
        mode = 2;
        pulse(0, c);
        push(0, c, 49, 14, 1, 1);
        wait_done(0, 60);

        // Mid-sweep start ignored, then start held through DONE re-triggers
        mode = 1;
        pulse(0, c);
        push(0, c, 49, 1, 15, 1);
        repeat (8) @(negedge clk);
        pulse(0, d);
        while (cyc < c + 48) @(negedge clk);
        start_a = 1'b1;
        push(0, c + 50, 49, 0, 0, 0);
        @(negedge clk);
        mode = 0;
        @(negedge clk);
        @(negedge clk);
        start_a = 1'b0;
        wait_done(0, 60);

        // Asynchronous abort while a_out == 6
        pulse(0, c);
        n = 0;
        while (a_a !== 4'd6 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("reached a_out=6", a_a, 6);
        #1 rst_n = 1'b0;
        #1 check_zero_a("abort");
        @(negedge clk);
        rst_n = 1'b1;
        pulse(0, c);
        push(0, c, 49, 0, 0, 0);
        wait_done(0, 60);

        // SETTLE=1 instance against an inverted gate
        pulse(1, c);
        push(1, c, 33, 16, 0, 1);
        wait_done(1, 45);

        repeat (3) @(negedge clk);
        check("scoreboard A drained", q_a.size(), 0);
        check("scoreboard B drained", q_b.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
